cond_resolve_unit: RTL and testbench

COND_RESOLVE_UNIT -- requirements
Module: cond_resolve_unit

---
 rtl/cond_resolve_unit_pkg.sv | 46 ++++
 rtl/cond_resolve_unit_eval.sv | 38 +++
 rtl/cond_resolve_unit.sv | 161 ++++++++++++++++
 tb/tb_cond_resolve_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cond_resolve_unit_pkg.sv
// Shared condition-resolution types: flag record, condition codes, request kinds
// and the resolve FSM state encoding.
package cond_resolve_unit_pkg;

  localparam int COND_WIRENUM = 4;

  typedef struct packed {
    logic zf;
    logic cf;
    logic sf;
    logic of;
  } FLAGS_t;

  typedef enum logic [COND_WIRENUM-1:0] {
    COND_E      = 4'd0,
    COND_NE     = 4'd1,
    COND_A      = 4'd2,
    COND_B      = 4'd3,
    COND_AE     = 4'd4,
    COND_BE     = 4'd5,
    COND_G      = 4'd6,
    COND_L      = 4'd7,
    COND_GE     = 4'd8,
    COND_LE     = 4'd9,
    COND_S      = 4'd10,
    COND_NS     = 4'd11,
    COND_O      = 4'd12,
    COND_NO     = 4'd13,
    COND_ALWAYS = 4'd14
  } cond_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [1:0] KIND_BRANCH = 2'b01;
  localparam logic [1:0] KIND_JUMP   = 2'b10;

  // Only a pure branch or a pure jump may report taken.
  function automatic logic kind_ok(input logic [1:0] kind);
    return (kind == KIND_BRANCH) || (kind == KIND_JUMP);
  endfunction

endpackage

// File: rtl/cond_resolve_unit_eval.sv
// Combinational condition decode: flags plus condition code -> taken.
// Unknown codes resolve to not-taken.
module cond_eval
  import cond_resolve_unit_pkg::*;
(
  input  FLAGS_t                  flags,
  input  logic [COND_WIRENUM-1:0] cond,
  output logic                    taken
);

  logic lt;

  assign lt = flags.sf ^ flags.of;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_E:      taken = flags.zf;
      COND_NE:     taken = ~flags.zf;
      COND_A:      taken = ~flags.cf & ~flags.zf;
      COND_B:      taken = flags.cf;
      COND_AE:     taken = ~flags.cf;
      COND_BE:     taken = flags.cf | flags.zf;
      COND_G:      taken = ~lt & ~flags.zf;
      COND_L:      taken = lt;
      COND_GE:     taken = ~lt;
      COND_LE:     taken = lt | flags.zf;
      COND_S:      taken = flags.sf;
      COND_NS:     taken = ~flags.sf;
      COND_O:      taken = flags.of;
      COND_NO:     taken = ~flags.of;
      COND_ALWAYS: taken = 1'b1;
      default:     taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_resolve_unit.sv
// Resolves branch/jump conditions against per-field flag registers, waiting on
// pending flag producers with a writeback bypass and a saturating stall counter.
module cond_resolve_unit
  import cond_resolve_unit_pkg::*;
#(
  parameter int NUM_FIELDS = 4,
  parameter int IDX_W      = $clog2(NUM_FIELDS),
  parameter int STALL_W    = 16
) (
  input  logic                    CLK,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    alloc_valid,
  input  logic [IDX_W-1:0]        alloc_idx,
  input  logic                    fw_valid,
  input  logic [IDX_W-1:0]        fw_idx,
  input  FLAGS_t                  fw_flags,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [IDX_W-1:0]        req_idx,
  input  logic [COND_WIRENUM-1:0] req_cond,
  input  logic [1:0]              req_kind,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic                    resp_taken,
  output logic                    resp_jumpmux,
  output logic                    resp_branchmux,
  output logic [NUM_FIELDS-1:0]   pending,
  output logic [STALL_W-1:0]      stall_cycles
);

  FLAGS_t                  fields_q [NUM_FIELDS];
  logic [NUM_FIELDS-1:0]   pending_q, pending_d;
  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        wait_idx_q;
  logic [COND_WIRENUM-1:0] wait_cond_q;
  logic [1:0]              wait_kind_q;
  logic                    taken_q;
  logic [1:0]              kind_q;
  logic [STALL_W-1:0]      stall_q;

  logic                    accept, load_resp, load_wait, stall_inc;
  FLAGS_t                  eval_flags;
  logic [COND_WIRENUM-1:0] eval_cond;
  logic [1:0]              eval_kind;
  logic                    eval_true;

  // rst_n gates ready so nothing is accepted while reset is held.
  assign req_ready = rst_n && (state_q == ST_IDLE) && !flush;
  assign accept    = req_valid && req_ready;

  cond_eval u_cond_eval (
    .flags (eval_flags),
    .cond  (eval_cond),
    .taken (eval_true)
  );

  always_comb begin
    state_d    = state_q;
    load_resp  = 1'b0;
    load_wait  = 1'b0;
    stall_inc  = 1'b0;
    eval_flags = fields_q[req_idx];
    eval_cond  = req_cond;
    eval_kind  = req_kind;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (!pending_q[req_idx]) begin
            state_d   = ST_RESP;
            load_resp = 1'b1;
          end else if (fw_valid && (fw_idx == req_idx)) begin
            eval_flags = fw_flags;
            state_d    = ST_RESP;
            load_resp  = 1'b1;
          end else begin
            state_d   = ST_WAIT;
            load_wait = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        eval_flags = fw_flags;
        eval_cond  = wait_cond_q;
        eval_kind  = wait_kind_q;
        if (fw_valid && (fw_idx == wait_idx_q)) begin
          state_d   = ST_RESP;
          load_resp = 1'b1;
        end else begin
          stall_inc = 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) begin
      state_d   = ST_IDLE;
      load_resp = 1'b0;
      load_wait = 1'b0;
      stall_inc = 1'b0;
    end
  end

  // Allocation is applied after the writeback clear so a same-index alloc wins.
  always_comb begin
    pending_d = pending_q;
    if (fw_valid)    pending_d[fw_idx]    = 1'b0;
    if (alloc_valid) pending_d[alloc_idx] = 1'b1;
    if (flush)       pending_d            = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // NOTE: the flag file is small and architecturally visible, so it is reset like any other register.
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_FIELDS; i++) fields_q[i] <= '0;
      pending_q <= '0;
    end else begin
      if (fw_valid) fields_q[fw_idx] <= fw_flags;
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      wait_idx_q  <= '0;
      wait_cond_q <= '0;
      wait_kind_q <= '0;
      taken_q     <= 1'b0;
      kind_q      <= '0;
      stall_q     <= '0;
    end else begin
      if (load_wait) begin
        wait_idx_q  <= req_idx;
        wait_cond_q <= req_cond;
        wait_kind_q <= req_kind;
      end
      if (load_resp) begin
        taken_q <= eval_true & kind_ok(eval_kind);
        kind_q  <= eval_kind;
      end
      if (stall_inc && (stall_q != '1))
        stall_q <= stall_q + {{(STALL_W-1){1'b0}}, 1'b1};
    end
  end

  assign resp_valid     = (state_q == ST_RESP);
  assign resp_taken     = taken_q;
  assign resp_jumpmux   = taken_q & kind_q[1];
  assign resp_branchmux = taken_q & kind_q[0];
  assign pending        = pending_q;
  assign stall_cycles   = stall_q;

endmodule

// File: tb/tb_cond_resolve_unit.sv
// Self-checking bench for cond_resolve_unit: directed scenarios followed by
// randomized traffic, all compared against a behavioural model each cycle.
module tb_cond_resolve_unit;
  import cond_resolve_unit_pkg::*;

  localparam int NF = 4;
  localparam int IW = 2;
  localparam int SW = 4;
  localparam int STALL_MAX = (1 << SW) - 1;

  logic                    CLK = 1'b0;
  logic                    rst_n;
  logic                    flush;
  logic                    alloc_valid;
  logic [IW-1:0]           alloc_idx;
  logic                    fw_valid;
  logic [IW-1:0]           fw_idx;
  FLAGS_t                  fw_flags;
  logic                    req_valid;
  logic                    req_ready;
  logic [IW-1:0]           req_idx;
  logic [COND_WIRENUM-1:0] req_cond;
  logic [1:0]              req_kind;
  logic                    resp_valid;
  logic                    resp_ready;
  logic                    resp_taken;
  logic                    resp_jumpmux;
  logic                    resp_branchmux;
  logic [NF-1:0]           pending;
  logic [SW-1:0]           stall_cycles;

  cond_resolve_unit #(.NUM_FIELDS(NF), .IDX_W(IW), .STALL_W(SW)) dut (
    .CLK            (CLK),
    .rst_n          (rst_n),
    .flush          (flush),
    .alloc_valid    (alloc_valid),
    .alloc_idx      (alloc_idx),
    .fw_valid       (fw_valid),
    .fw_idx         (fw_idx),
    .fw_flags       (fw_flags),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_idx        (req_idx),
    .req_cond       (req_cond),
    .req_kind       (req_kind),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_taken     (resp_taken),
    .resp_jumpmux   (resp_jumpmux),
    .resp_branchmux (resp_branchmux),
    .pending        (pending),
    .stall_cycles   (stall_cycles)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Behavioural model: flag file, pending set, one outstanding request at most.
  logic [3:0] m_fld [NF];
  bit [NF-1:0] m_pend;
  bit          m_busy_wait;
  bit          m_has_resp;
  logic [IW-1:0] m_widx;
  logic [3:0]  m_wcond;
  logic [1:0]  m_wkind;
  bit          m_taken, m_jump, m_branch;
  int          m_stall;

  function automatic bit ref_cond(input logic [3:0] f, input logic [3:0] c);
    bit zf, cf, sf, ovf;
    zf = f[3]; cf = f[2]; sf = f[1]; ovf = f[0];
    case (c)
      4'd0:  return zf;
      4'd1:  return !zf;
      4'd2:  return !cf && !zf;
      4'd3:  return cf;
      4'd4:  return !cf;
      4'd5:  return cf || zf;
      4'd6:  return (sf == ovf) && !zf;
      4'd7:  return sf != ovf;
      4'd8:  return sf == ovf;
      4'd9:  return (sf != ovf) || zf;
      4'd10: return sf;
      4'd11: return !sf;
      4'd12: return ovf;
      4'd13: return !ovf;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NF; i++) m_fld[i] = 4'h0;
    m_pend = '0;
    m_busy_wait = 0; m_has_resp = 0;
    m_taken = 0; m_jump = 0; m_branch = 0;
    m_stall = 0;
  endtask

  task automatic model_respond(input logic [3:0] f, input logic [3:0] c, input logic [1:0] k);
    bit t;
    t = ref_cond(f, c) && (k == 2'b01 || k == 2'b10);
    m_taken = t; m_jump = t && (k == 2'b10); m_branch = t && (k == 2'b01);
    m_has_resp = 1; m_busy_wait = 0;
  endtask

  task automatic idle_inputs();
    flush = 0; alloc_valid = 0; alloc_idx = '0;
    fw_valid = 0; fw_idx = '0; fw_flags = '0;
    req_valid = 0; req_idx = '0; req_cond = '0; req_kind = '0;
    resp_ready = 1;
  endtask

  // One clock: compare outputs with the model, advance the model, cross the edge.
  task automatic tick();
    bit exp_ready;
    exp_ready = !m_busy_wait && !m_has_resp && !flush;
    #1;
    check("req_ready", req_ready, exp_ready);
    check("resp_valid", resp_valid, m_has_resp);
    if (m_has_resp) begin
      check("resp_taken", resp_taken, m_taken);
      check("resp_jumpmux", resp_jumpmux, m_jump);
      check("resp_branchmux", resp_branchmux, m_branch);
    end
    check("pending", pending, m_pend);
    check("stall_cycles", stall_cycles, m_stall);

    if (flush) begin
      m_busy_wait = 0; m_has_resp = 0;
    end else if (m_has_resp) begin
      if (resp_ready) m_has_resp = 0;
    end else if (m_busy_wait) begin
      if (fw_valid && fw_idx == m_widx) model_respond(fw_flags, m_wcond, m_wkind);
      else if (m_stall < STALL_MAX) m_stall++;
    end else if (req_valid && exp_ready) begin
      if (!m_pend[req_idx])                     model_respond(m_fld[req_idx], req_cond, req_kind);
      else if (fw_valid && fw_idx == req_idx)   model_respond(fw_flags, req_cond, req_kind);
      else begin
        m_busy_wait = 1; m_widx = req_idx; m_wcond = req_cond; m_wkind = req_kind;
      end
    end
    if (fw_valid) begin
      m_fld[fw_idx] = fw_flags;
      m_pend[fw_idx] = 0;
    end
    if (alloc_valid) m_pend[alloc_idx] = 1;
    if (flush) m_pend = '0;

    @(posedge CLK);
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic probe_resp(input string tag, input bit t, input bit j, input bit b);
    #1;
    check({tag, "_valid"}, resp_valid, 1'b1);
    check({tag, "_taken"}, resp_taken, t);
    check({tag, "_jump"}, resp_jumpmux, j);
    check({tag, "_branch"}, resp_branchmux, b);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    model_reset();
    rst_n = 0;
    repeat (2) @(negedge CLK);
    #1;
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_taken", resp_taken, 1'b0);
    check("rst_pending", pending, '0);
    check("rst_stall", stall_cycles, '0);
    rst_n = 1;
    @(negedge CLK);

    // Stored-field resolve, latency 1.
    fw_valid = 1; fw_idx = 2; fw_flags = 4'b1000; tick();
    req_valid = 1; req_idx = 2; req_cond = COND_E; req_kind = 2'b01; tick();
    probe_resp("d_stored", 1, 0, 1);
    tick();

    // Pending field: wait four cycles while unrelated fields are written back.
    alloc_valid = 1; alloc_idx = 1; tick();
    req_valid = 1; req_idx = 1; req_cond = COND_L; req_kind = 2'b10; tick();
    for (int i = 0; i < 4; i++) begin
      fw_valid = i[0]; fw_idx = (i < 2) ? 2'd3 : 2'd0; fw_flags = 4'($urandom); tick();
    end
    check("d_wait_stall", stall_cycles, 4);
    fw_valid = 1; fw_idx = 1; fw_flags = 4'b0010; tick();
    probe_resp("d_wait", 1, 1, 0);
    tick();

    // Bypass: request and writeback to a pending field in the same cycle.
    alloc_valid = 1; alloc_idx = 0; tick();
    req_valid = 1; req_idx = 0; req_cond = COND_B; req_kind = 2'b01;
    fw_valid = 1; fw_idx = 0; fw_flags = 4'b0100; tick();
    probe_resp("d_bypass", 1, 0, 1);
    check("d_bypass_stall", stall_cycles, 4);
    tick();

    // Stall counter saturates at all-ones.
    alloc_valid = 1; alloc_idx = 1; tick();
    req_valid = 1; req_idx = 1; req_cond = COND_NE; req_kind = 2'b01; tick();
    repeat (13) tick();
    check("d_stall_sat", stall_cycles, STALL_MAX);
    tick();
    fw_valid = 1; fw_idx = 1; fw_flags = 4'b0000; tick();
    probe_resp("d_sat", 1, 0, 1);
    tick();

    // Backpressure: response held stable while resp_ready is low.
    req_valid = 1; req_idx = 3; req_cond = COND_ALWAYS; req_kind = 2'b10; tick();
    for (int i = 0; i < 3; i++) begin
      resp_ready = 0;
      probe_resp("d_hold", 1, 1, 0);
      check("d_hold_ready", req_ready, 1'b0);
      tick();
    end
    tick();
    #1;
    check("d_hold_idle_ready", req_ready, 1'b1);
    check("d_hold_idle_valid", resp_valid, 1'b0);

    // Flush during WAIT overrides a same-cycle alloc.
    alloc_valid = 1; alloc_idx = 2; tick();
    req_valid = 1; req_idx = 2; req_cond = COND_E; req_kind = 2'b01; tick();
    flush = 1; alloc_valid = 1; alloc_idx = 3; tick();
    #1;
    check("d_flush_valid", resp_valid, 1'b0);
    check("d_flush_pending", pending, '0);
    check("d_flush_ready", req_ready, 1'b1);

    // Asynchronous reset while a response is pending.
    req_valid = 1; req_idx = 0; req_cond = COND_NE; req_kind = 2'b01; tick();
    probe_resp("d_pre_rst", 1, 0, 1);
    rst_n = 0;
    #1;
    check("arst_valid", resp_valid, 1'b0);
    check("arst_taken", resp_taken, 1'b0);
    check("arst_jump", resp_jumpmux, 1'b0);
    check("arst_branch", resp_branchmux, 1'b0);
    check("arst_ready", req_ready, 1'b0);
    check("arst_stall", stall_cycles, '0);
    model_reset();
    @(negedge CLK);
    rst_n = 1;
    @(negedge CLK);
    idle_inputs();
    req_valid = 1; req_idx = 0; req_cond = COND_NE; req_kind = 2'b01; tick();
    probe_resp("d_post_rst", 1, 0, 1);
    tick();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      flush       = ($urandom_range(0, 99) < 3);
      alloc_valid = ($urandom_range(0, 99) < 25);
      alloc_idx   = 2'($urandom_range(0, NF - 1));
      fw_valid    = ($urandom_range(0, 99) < 35);
      fw_idx      = 2'($urandom_range(0, NF - 1));
      fw_flags    = 4'($urandom);
      req_valid   = ($urandom_range(0, 99) < 50);
      req_idx     = 2'($urandom_range(0, NF - 1));
      req_cond    = 4'($urandom_range(0, 15));
      req_kind    = 2'($urandom_range(0, 3));
      resp_ready  = ($urandom_range(0, 99) < 70);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
